if_id_skid_stage: RTL and testbench
===================================

// Module: if_id_skid_stage
// PURPOSE
//   Parametrised IF/ID pipeline boundary register with valid/ready handshake, a 2-entry skid buffer,
//   synchronous flush and a stall counter. Sits between fetch (PC, instruction, PC+4 packed into
//   in_data_i) and decode. Supports full throughput under backpressure without a combinational
//   ready path, and injects a bubble on flush.
// PARAMETERS
//   DATA_W       96            payload width: {address[31:0], instr[31:0], pc_add4[31:0]}
//   BUBBLE_DATA  {DATA_W{1'b0}} value driven on out_data_o whenever out_valid_o=0 (NOP bubble)
//   CNT_W        16            width of saturating stall counter
// PORTS
//   clk_i        in   1        clock, rising edge
//   rst_i        in   1        asynchronous reset, active-high
//   in_valid_i   in   1        fetch presents valid payload
//   in_ready_o   out  1        stage can accept payload this cycle
//   in_data_i    in   DATA_W   fetch payload
//   out_valid_o  out  1        decode payload valid
//   out_ready_i  in   1        decode accepts payload this cycle
//   out_data_o   out  DATA_W   decode payload
//   flush_i      in   1        discard all held and incoming payload (branch/jump redirect)
//   occupancy_o  out  2        entries held: 0, 1 or 2
//   stall_cnt_o  out  CNT_W    cycles with out_valid_o=1 and out_ready_i=0, saturating
// BEHAVIOUR
//   - Storage: main reg (drives out_data_o) + skid reg. States EMPTY(occ 0), ONE(occ 1), FULL(occ 2).
//   - Accept = in_valid_i & in_ready_o; Pop = out_valid_o & out_ready_i.
//   - in_ready_o = (state != FULL), decoded from registered state only; no path from out_ready_i.
//   - out_valid_o = (state != EMPTY); out_data_o = main reg; main reg holds BUBBLE_DATA when EMPTY.
//   - Transitions (no flush):
//       EMPTY: Accept -> ONE, main<=in_data_i; else stay.
//       ONE:   Accept&Pop -> ONE, main<=in_data_i; Accept&~Pop -> FULL, skid<=in_data_i;
//              ~Accept&Pop -> EMPTY, main<=BUBBLE_DATA; else hold.
//       FULL:  Pop -> ONE, main<=skid, skid<=BUBBLE_DATA; else hold (no Accept possible).
//   - Order preserved: skid entry is always younger than main entry.
//   - Latency: EMPTY + Accept at edge N -> out_valid_o=1 with that payload after edge N. Throughput 1/cycle.
//   - Payload stable while out_valid_o=1 and out_ready_i=0.
//   - flush_i (synchronous, highest priority): next state EMPTY, main and skid <= BUBBLE_DATA; any
//     Accept in the same cycle is dropped; a same-cycle Pop still counts as completed for decode.
//   - Stall counter: +1 per cycle with out_valid_o & ~out_ready_i; saturates at 2^CNT_W-1; cleared
//     only by reset; flush does not clear it.
//   - Reset (async assert, any state, mid-transfer included): state EMPTY, main/skid=BUBBLE_DATA,
//     out_valid_o=0, in_ready_o=1, occupancy_o=0, stall_cnt_o=0. Deassertion is synchronised upstream.
//   - in_data_i ignored when Accept=0; X on in_data_i must not propagate when in_valid_i=0.
// TESTING
//   1. Reset then in_valid_i=1, data 0xA..., out_ready_i=1 each cycle, 8 items -> out_data_o matches
//      one cycle later, out_valid_o=1 every cycle, occupancy_o=1, stall_cnt_o=0.
//   2. out_ready_i=0 while pushing D0,D1,D2 -> D0 in main, D1 in skid, occupancy_o=2, in_ready_o=0,
//      D2 held upstream; release out_ready_i -> outputs D0,D1,D2 in order, none lost or duplicated.
//   3. FULL, assert flush_i with in_valid_i=1 -> next cycle occupancy_o=0, out_valid_o=0,
//      out_data_o=BUBBLE_DATA, incoming payload dropped; stall_cnt_o unchanged by flush.
//   4. Hold out_ready_i=0 with out_valid_o=1 for 2^CNT_W+5 cycles (CNT_W=4) -> stall_cnt_o sticks at 15.
//   5. Assert rst_i asynchronously between edges while FULL -> outputs immediately at reset values,
//      in_ready_o=1; after release, first push appears after 1 cycle.
//   6. Random valid/ready/flush (10k cycles) vs scoreboard -> order preserved, no loss except flushed entries.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - IF/ID pipeline boundary with 2-entry skid buffer, flush and stall counter
//
// Purpose:
//   Registered valid/ready boundary between fetch and decode. A main register
//   drives decode and a skid register absorbs one extra payload, so in_ready_o
//   comes from registered state only and full throughput is sustained under
//   backpressure. A flush empties both entries and leaves a bubble on the output.
//
// Ports:
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       asynchronous reset, active-high
//   in_valid_i   in   1       fetch presents valid payload
//   in_ready_o   out  1       stage can accept payload this cycle
//   in_data_i    in   DATA_W  fetch payload {address, instr, pc_add4}
//   out_valid_o  out  1       decode payload valid
//   out_ready_i  in   1       decode accepts payload this cycle
//   out_data_o   out  DATA_W  decode payload (BUBBLE_DATA when not valid)
//   flush_i      in   1       discard held and incoming payload
//   occupancy_o  out  2       entries held: 0, 1 or 2
//   stall_cnt_o  out  CNT_W   saturating count of valid & ~ready cycles

module if_id_skid_stage #(
    parameter int                 DATA_W      = 96,
    parameter logic [DATA_W-1:0]  BUBBLE_DATA = '0,
    parameter int                 CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              flush_i,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Encoding equals the number of entries held, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic accept;
    logic pop;

    // Handshake outputs depend on registered state only; out_ready_i never
    // reaches in_ready_o combinationally.
    assign in_ready_o  = (state_q != ST_FULL);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;
    assign occupancy_o = state_q;
    assign stall_cnt_o = stall_cnt_q;

    assign accept = in_valid_i & in_ready_o;
    assign pop    = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush_i) begin
            // Flush wins over everything; an accept in this cycle is dropped.
            state_d = ST_EMPTY;
            main_d  = BUBBLE_DATA;
            skid_d  = BUBBLE_DATA;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_d = in_data_i;
                    end else if (accept) begin
                        // Decode stalled: newer payload parks behind main.
                        state_d = ST_FULL;
                        skid_d  = in_data_i;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE_DATA;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_DATA;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_DATA;
                    skid_d  = BUBBLE_DATA;
                end
            endcase
        end
    end

    // Stall counter is independent of flush and saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            main_q      <= BUBBLE_DATA;
            skid_q      <= BUBBLE_DATA;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - directed and random checks of if_id_skid_stage

module tb_if_id_skid_stage;

    localparam int          DATA_W = 96;
    localparam int          CNT_W  = 4;
    localparam logic [95:0] BUBBLE = '0;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int n_vec = 0;
    int n_bad = 0;

    logic [95:0] mq[$];
    logic [95:0] popped[$];
    int unsigned mstall = 0;

    if_id_skid_stage #(
        .DATA_W      (DATA_W),
        .BUBBLE_DATA (BUBBLE),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .flush_i     (flush),
        .occupancy_o (occupancy),
        .stall_cnt_o (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] mk(input logic [31:0] addr, input logic [31:0] instr);
        return {addr, instr, addr + 32'd4};
    endfunction

    // One clock: drive at negedge, compare against queue model, update model after posedge.
    task automatic cycle(input logic v, input logic [95:0] d, input logic r, input logic f);
        logic acc;
        logic pp;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
        check_vec("out_valid", out_valid, mq.size() > 0);
        check_vec("out_data", out_data, (mq.size() > 0) ? mq[0] : BUBBLE);
        check_vec("in_ready", in_ready, mq.size() < 2);
        check_vec("occupancy", occupancy, mq.size());
        check_vec("stall_cnt", stall_cnt, mstall);
        acc = v && (mq.size() < 2);
        pp  = (mq.size() > 0) && r;
        if (pp) popped.push_back(mq[0]);
        if ((mq.size() > 0) && !r && (mstall < 15)) mstall++;
        @(posedge clk);
        if (f) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        popped.delete();
        mstall = 0;
    endtask

    initial begin
        logic [95:0] d0, d1, d2, g0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2;
        check_vec("rst_out_valid", out_valid, 1'b0);
        check_vec("rst_in_ready", in_ready, 1'b1);
        check_vec("rst_occupancy", occupancy, 2'd0);
        check_vec("rst_stall", stall_cnt, 4'd0);
        check_vec("rst_out_data", out_data, BUBBLE);
        do_reset();

        // 1: streaming, one-cycle latency, no stalls
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, mk(32'h0000_1000 + 32'(i * 4), 32'hA000_0000 | 32'(i)), 1'b1, 1'b0);
            #2;
            check_vec("t1_data", out_data, mk(32'h0000_1000 + 32'(i * 4), 32'hA000_0000 | 32'(i)));
            check_vec("t1_valid", out_valid, 1'b1);
            check_vec("t1_occ", occupancy, 2'd1);
        end
        check_vec("t1_stall", stall_cnt, 4'd0);
        check_vec("t1_popped", popped.size(), 7);

        // 2: backpressure fills skid, release drains in order
        do_reset();
        d0 = mk(32'h0000_2000, 32'hD0D0_0000);
        d1 = mk(32'h0000_2004, 32'hD1D1_0001);
        d2 = mk(32'h0000_2008, 32'hD2D2_0002);
        cycle(1'b1, d0, 1'b0, 1'b0);
        cycle(1'b1, d1, 1'b0, 1'b0);
        cycle(1'b1, d2, 1'b0, 1'b0);
        #2;
        check_vec("t2_main", out_data, d0);
        check_vec("t2_occ", occupancy, 2'd2);
        check_vec("t2_in_ready", in_ready, 1'b0);
        cycle(1'b1, d2, 1'b1, 1'b0);
        #2;
        check_vec("t2_after_pop0", out_data, d1);
        cycle(1'b1, d2, 1'b1, 1'b0);
        cycle(1'b0, 'x, 1'b1, 1'b0);
        check_vec("t2_count", popped.size(), 3);
        if (popped.size() == 3) begin
            check_vec("t2_pop0", popped[0], d0);
            check_vec("t2_pop1", popped[1], d1);
            check_vec("t2_pop2", popped[2], d2);
        end
        #2;
        check_vec("t2_empty", occupancy, 2'd0);

        // 3: flush while FULL with incoming payload
        do_reset();
        cycle(1'b1, mk(32'h0000_3000, 32'hE000_0000), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h0000_3004, 32'hE000_0001), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h0000_3008, 32'hE000_0002), 1'b0, 1'b1);
        #2;
        check_vec("t3_occ", occupancy, 2'd0);
        check_vec("t3_valid", out_valid, 1'b0);
        check_vec("t3_data", out_data, BUBBLE);
        check_vec("t3_stall", stall_cnt, 4'd2);
        cycle(1'b0, 'x, 1'b1, 1'b0);
        check_vec("t3_nothing_out", popped.size(), 0);

        // 4: stall counter saturation
        do_reset();
        cycle(1'b1, mk(32'h0000_4000, 32'hF000_0000), 1'b0, 1'b0);
        for (int i = 0; i < 21; i++) cycle(1'b0, 'x, 1'b0, 1'b0);
        #2;
        check_vec("t4_sat", stall_cnt, 4'd15);

        // 5: asynchronous reset between edges while FULL
        do_reset();
        cycle(1'b1, mk(32'h0000_5000, 32'h5000_0000), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h0000_5004, 32'h5000_0001), 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_vec("t5_valid", out_valid, 1'b0);
        check_vec("t5_in_ready", in_ready, 1'b1);
        check_vec("t5_occ", occupancy, 2'd0);
        check_vec("t5_stall", stall_cnt, 4'd0);
        check_vec("t5_data", out_data, BUBBLE);
        mq.delete();
        popped.delete();
        mstall = 0;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        g0 = mk(32'h0000_6000, 32'h6000_0000);
        cycle(1'b1, g0, 1'b1, 1'b0);
        #2;
        check_vec("t5_first", out_data, g0);
        check_vec("t5_first_valid", out_valid, 1'b1);

        // 6: random traffic against the queue model
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            logic v, r, f;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 31) == 0);
            cycle(v, v ? {$urandom, $urandom, $urandom} : 96'bx, r, f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
